// File: rtl/mxa_job_scheduler.sv
// mxa_job_scheduler: job-level sequencer in front of matrix_accelerator.
// It accepts one command, then for each tile it fetches operands (op_req/op_ack)
// and drives valid_mac until mac_calc_done. On the last tile it can run an
// optional PPU pass. A watchdog aborts a RUN or PPU_WAIT that stalls too long.
// Status goes back on an rsp_valid/rsp_ready handshake.
// Ports:
//   clk, rst (synchronous, active-high)
//   cmd_*      : command handshake and payload (mode, vsq, tiles, scale, bias, ppu_en)
//   op_*       : operand fetch request/ack and the tile index being fetched
//   is_*/valid_*/scale/bias : accelerator controls, held for the whole job
//   mac_calc_done, acc_done : completion pulses from the accelerator
//   rsp_*      : response handshake carrying tiles completed and error code
//   busy       : high whenever the scheduler is not IDLE
// Optional: defining MXA_SCHED_PERF_EN adds saturating perf_busy_cycles and
// perf_fetch_stall counters.
module mxa_job_scheduler #(
  parameter int unsigned TILE_W     = 8,
  parameter int unsigned TMO_W      = 12,
  parameter int unsigned TMO_CYCLES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic              cmd_vsq,
  input  logic [TILE_W-1:0] cmd_tiles,
  input  logic [7:0]        cmd_scale,
  input  logic [7:0]        cmd_bias,
  input  logic              cmd_ppu_en,
  output logic              op_req,
  output logic [TILE_W-1:0] op_tile_idx,
  input  logic              op_ack,
  output logic              is_int8_mode,
  output logic              is_int4_mode,
  output logic              is_vsq,
  output logic              valid_mac,
  output logic              valid_ppu,
  output logic [7:0]        scale,
  output logic [7:0]        bias,
  input  logic              mac_calc_done,
  input  logic              acc_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TILE_W-1:0] rsp_tiles,
  output logic [1:0]        rsp_err,
  output logic              busy
`ifdef MXA_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_fetch_stall
`endif
);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_MODE    = 2'd2;
  localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'(TMO_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PPU_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   idx_q, idx_d;
  logic [TILE_W-1:0]   tiles_q, tiles_d;
  logic [TILE_W-1:0]   done_cnt_q, done_cnt_d;
  logic [TMO_W-1:0]    wdog_q, wdog_d;
  logic                ppu_en_q, ppu_en_d;
  logic                int8_d, int4_d, vsq_d;
  logic [7:0]          scale_d, bias_d;
  logic [TILE_W-1:0]   rsp_tiles_d;
  logic [1:0]          rsp_err_d;
  logic                last_tile_q;
  logic                wdog_expired;
  logic [TILE_W-1:0]   idx_inc;

  assign last_tile_q  = (idx_q == TILE_W'(tiles_q - TILE_W'(1)));
  assign wdog_expired = (wdog_q == WDOG_LAST);
  assign idx_inc      = TILE_W'(idx_q + TILE_W'(1));

  // Next-state and next-register values; outputs are registered from these.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tiles_d     = tiles_q;
    done_cnt_d  = done_cnt_q;
    wdog_d      = wdog_q;
    ppu_en_d    = ppu_en_q;
    int8_d      = is_int8_mode;
    int4_d      = is_int4_mode;
    vsq_d       = is_vsq;
    scale_d     = scale;
    bias_d      = bias;
    rsp_tiles_d = rsp_tiles;
    rsp_err_d   = rsp_err;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          idx_d      = '0;
          done_cnt_d = '0;
          wdog_d     = '0;
          tiles_d    = cmd_tiles;
          ppu_en_d   = cmd_ppu_en;
          int8_d     = (cmd_mode == 2'd1);
          int4_d     = (cmd_mode == 2'd2);
          vsq_d      = cmd_vsq;
          scale_d    = cmd_scale;
          bias_d     = cmd_bias;
          if (cmd_mode == 2'd3) begin
            state_d     = S_RESP;
            rsp_err_d   = ERR_MODE;
            rsp_tiles_d = '0;
          end else if (cmd_tiles == '0) begin
            state_d     = S_RESP;
            rsp_err_d   = ERR_OK;
            rsp_tiles_d = '0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (op_ack) begin
          state_d = S_RUN;
          wdog_d  = '0;
        end
      end
      S_RUN: begin
        // A completion in the expiry cycle wins over the timeout.
        if (mac_calc_done) begin
          done_cnt_d = idx_inc;
          if (!last_tile_q) begin
            idx_d   = idx_inc;
            state_d = S_LOAD;
          end else if (ppu_en_q) begin
            state_d = S_PPU_WAIT;
            wdog_d  = '0;
          end else begin
            state_d     = S_RESP;
            rsp_err_d   = ERR_OK;
            rsp_tiles_d = idx_inc;
          end
        end else if (wdog_expired) begin
          state_d     = S_RESP;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_tiles_d = done_cnt_q;
        end else begin
          wdog_d = TMO_W'(wdog_q + TMO_W'(1));
        end
      end
      S_PPU_WAIT: begin
        if (acc_done) begin
          state_d     = S_RESP;
          rsp_err_d   = ERR_OK;
          rsp_tiles_d = done_cnt_q;
        end else if (wdog_expired) begin
          state_d     = S_RESP;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_tiles_d = done_cnt_q;
        end else begin
          wdog_d = TMO_W'(wdog_q + TMO_W'(1));
        end
      end
      S_RESP: begin
        // Job settings and status clear on the way back to IDLE.
        if (rsp_ready) begin
          state_d     = S_IDLE;
          int8_d      = 1'b0;
          int4_d      = 1'b0;
          vsq_d       = 1'b0;
          scale_d     = '0;
          bias_d      = '0;
          rsp_tiles_d = '0;
          rsp_err_d   = ERR_OK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, job context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tiles_q      <= '0;
      done_cnt_q   <= '0;
      wdog_q       <= '0;
      ppu_en_q     <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      op_req       <= 1'b0;
      op_tile_idx  <= '0;
      is_int8_mode <= 1'b0;
      is_int4_mode <= 1'b0;
      is_vsq       <= 1'b0;
      scale        <= '0;
      bias         <= '0;
      valid_mac    <= 1'b0;
      valid_ppu    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_tiles    <= '0;
      rsp_err      <= ERR_OK;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tiles_q      <= tiles_d;
      done_cnt_q   <= done_cnt_d;
      wdog_q       <= wdog_d;
      ppu_en_q     <= ppu_en_d;
      cmd_ready    <= (state_d == S_IDLE);
      busy         <= (state_d != S_IDLE);
      op_req       <= (state_d == S_LOAD);
      op_tile_idx  <= idx_d;
      is_int8_mode <= int8_d;
      is_int4_mode <= int4_d;
      is_vsq       <= vsq_d;
      scale        <= scale_d;
      bias         <= bias_d;
      valid_mac    <= (state_d == S_RUN);
      valid_ppu    <= (state_d == S_RUN) && ppu_en_d &&
                      (idx_d == TILE_W'(tiles_d - TILE_W'(1)));
      rsp_valid    <= (state_d == S_RESP);
      rsp_tiles    <= rsp_tiles_d;
      rsp_err      <= rsp_err_d;
    end
  end

`ifdef MXA_SCHED_PERF_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_fetch_stall <= '0;
    end else begin
      if ((state_q != S_IDLE) && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if ((state_q == S_LOAD) && !op_ack && (perf_fetch_stall != '1))
        perf_fetch_stall <= perf_fetch_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mxa_job_scheduler.sv
// Directed bench for mxa_job_scheduler: multi-tile jobs, PPU pass, watchdog
// timeout, illegal/empty commands, response back-pressure and mid-job reset.
module tb_mxa_job_scheduler;

  localparam int unsigned TILE_W     = 8;
  localparam int unsigned TMO_CYCLES = 2048;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic              cmd_vsq;
  logic [TILE_W-1:0] cmd_tiles;
  logic [7:0]        cmd_scale;
  logic [7:0]        cmd_bias;
  logic              cmd_ppu_en;
  logic              op_req;
  logic [TILE_W-1:0] op_tile_idx;
  logic              op_ack;
  logic              is_int8_mode;
  logic              is_int4_mode;
  logic              is_vsq;
  logic              valid_mac;
  logic              valid_ppu;
  logic [7:0]        scale;
  logic [7:0]        bias;
  logic              mac_calc_done;
  logic              acc_done;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [TILE_W-1:0] rsp_tiles;
  logic [1:0]        rsp_err;
  logic              busy;

  int checks;
  int failures;

  mxa_job_scheduler #(.TILE_W(TILE_W), .TMO_W(12), .TMO_CYCLES(TMO_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_vsq(cmd_vsq), .cmd_tiles(cmd_tiles), .cmd_scale(cmd_scale),
    .cmd_bias(cmd_bias), .cmd_ppu_en(cmd_ppu_en),
    .op_req(op_req), .op_tile_idx(op_tile_idx), .op_ack(op_ack),
    .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode), .is_vsq(is_vsq),
    .valid_mac(valid_mac), .valid_ppu(valid_ppu), .scale(scale), .bias(bias),
    .mac_calc_done(mac_calc_done), .acc_done(acc_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tiles(rsp_tiles),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] mode, input logic vsq, input int tiles,
                          input logic [7:0] sc, input logic [7:0] bi, input logic ppu);
    cmd_mode   = mode;
    cmd_vsq    = vsq;
    cmd_tiles  = TILE_W'(tiles);
    cmd_scale  = sc;
    cmd_bias   = bi;
    cmd_ppu_en = ppu;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Fetch one tile with a one-cycle ack delay; returns just after entering RUN.
  task automatic load_tile(input int idx, input logic exp_ppu);
    chk($sformatf("op_req_t%0d", idx), 32'(op_req), 32'd1);
    chk($sformatf("op_idx_t%0d", idx), 32'(op_tile_idx), 32'(idx));
    chk($sformatf("load_no_mac_t%0d", idx), 32'(valid_mac), 32'd0);
    tick();
    op_ack = 1'b1;
    tick();
    op_ack = 1'b0;
    chk($sformatf("run_mac_t%0d", idx), 32'(valid_mac), 32'd1);
    chk($sformatf("run_no_req_t%0d", idx), 32'(op_req), 32'd0);
    chk($sformatf("run_ppu_t%0d", idx), 32'(valid_ppu), 32'(exp_ppu));
  endtask

  // Stay in RUN for run_cycles cycles, pulsing mac_calc_done in the last one.
  task automatic finish_run(input int run_cycles);
    repeat (run_cycles - 1) tick();
    mac_calc_done = 1'b1;
    tick();
    mac_calc_done = 1'b0;
    chk("mac_drop", 32'(valid_mac), 32'd0);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_rsp_clear", 32'(rsp_valid), 32'd0);
    chk("hs_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("hs_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic early;
    logic unstable;
    logic saw_rsp;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_vsq = 1'b0; cmd_tiles = '0;
    cmd_scale = '0; cmd_bias = '0; cmd_ppu_en = 1'b0;
    op_ack = 1'b0; mac_calc_done = 1'b0; acc_done = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_req", 32'(op_req), 32'd0);
    chk("rst_valid_mac", 32'(valid_mac), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_scale", 32'(scale), 32'd0);

    // Stray completion/ack pulses in IDLE are ignored
    mac_calc_done = 1'b1; acc_done = 1'b1; op_ack = 1'b1;
    tick();
    mac_calc_done = 1'b0; acc_done = 1'b0; op_ack = 1'b0;
    chk("ign_idle_busy", 32'(busy), 32'd0);
    chk("ign_idle_rsp", 32'(rsp_valid), 32'd0);

    // Job 1: int8, 3 tiles, no PPU, 32-cycle MAC per tile
    send_cmd(2'd1, 1'b0, 3, 8'h00, 8'h00, 1'b0);
    chk("j1_cmd_ready_low", 32'(cmd_ready), 32'd0);
    chk("j1_int8", 32'(is_int8_mode), 32'd1);
    chk("j1_int4", 32'(is_int4_mode), 32'd0);
    for (int t = 0; t < 3; t++) begin
      load_tile(t, 1'b0);
      chk($sformatf("j1_int8_t%0d", t), 32'(is_int8_mode), 32'd1);
      finish_run(32);
    end
    chk("j1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("j1_rsp_tiles", 32'(rsp_tiles), 32'd3);
    chk("j1_rsp_err", 32'(rsp_err), 32'd0);
    handshake();
    chk("j1_int8_cleared", 32'(is_int8_mode), 32'd0);

    // Job 2: int4 + VSQ, 2 tiles, PPU on last tile
    send_cmd(2'd2, 1'b1, 2, 8'h10, 8'h04, 1'b1);
    load_tile(0, 1'b0);
    finish_run(5);
    load_tile(1, 1'b1);
    finish_run(5);
    chk("j2_ppu_wait_ppu", 32'(valid_ppu), 32'd0);
    chk("j2_ppu_wait_busy", 32'(busy), 32'd1);
    chk("j2_ppu_wait_norsp", 32'(rsp_valid), 32'd0);
    repeat (3) tick();
    chk("j2_scale", 32'(scale), 32'h10);
    chk("j2_bias", 32'(bias), 32'h04);
    chk("j2_int4", 32'(is_int4_mode), 32'd1);
    chk("j2_vsq", 32'(is_vsq), 32'd1);
    chk("j2_still_wait", 32'(rsp_valid), 32'd0);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("j2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("j2_rsp_tiles", 32'(rsp_tiles), 32'd2);
    chk("j2_rsp_err", 32'(rsp_err), 32'd0);
    handshake();

    // Job 3: 4 tiles, tile 2 never completes -> watchdog timeout
    send_cmd(2'd0, 1'b0, 4, 8'h00, 8'h00, 1'b0);
    load_tile(0, 1'b0);
    finish_run(4);
    load_tile(1, 1'b0);
    finish_run(4);
    load_tile(2, 1'b0);
    early = 1'b0;
    for (int k = 1; k < TMO_CYCLES; k++) begin
      tick();
      if (rsp_valid !== 1'b0 || valid_mac !== 1'b1) early = 1'b1;
    end
    chk("j3_no_early_tmo", 32'(early), 32'd0);
    tick();
    chk("j3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("j3_rsp_err", 32'(rsp_err), 32'd1);
    chk("j3_rsp_tiles", 32'(rsp_tiles), 32'd2);
    chk("j3_mac_drop", 32'(valid_mac), 32'd0);
    // Back-pressure: response held stable while rsp_ready is low
    unstable = 1'b0;
    repeat (5) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_err !== 2'd1 || rsp_tiles !== 8'd2 ||
          cmd_ready !== 1'b0) unstable = 1'b1;
    end
    chk("j3_rsp_stable", 32'(unstable), 32'd0);
    handshake();

    // Illegal mode: straight to response, no fetch
    send_cmd(2'd3, 1'b0, 5, 8'h00, 8'h00, 1'b0);
    chk("ill_no_op_req", 32'(op_req), 32'd0);
    chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill_rsp_err", 32'(rsp_err), 32'd2);
    chk("ill_rsp_tiles", 32'(rsp_tiles), 32'd0);
    handshake();

    // Zero tiles: immediate ok response
    send_cmd(2'd0, 1'b0, 0, 8'h00, 8'h00, 1'b0);
    chk("zero_no_op_req", 32'(op_req), 32'd0);
    chk("zero_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("zero_rsp_err", 32'(rsp_err), 32'd0);
    chk("zero_rsp_tiles", 32'(rsp_tiles), 32'd0);
    handshake();

    // Reset in the RUN of tile 1
    send_cmd(2'd1, 1'b0, 3, 8'h22, 8'h33, 1'b0);
    load_tile(0, 1'b0);
    finish_run(3);
    load_tile(1, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_valid_mac", 32'(valid_mac), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_scale", 32'(scale), 32'd0);
    saw_rsp = 1'b0;
    mac_calc_done = 1'b1;
    tick();
    mac_calc_done = 1'b0;
    repeat (20) begin
      tick();
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    chk("mid_rst_no_rsp", 32'(saw_rsp), 32'd0);

    // Single tile with zero-wait fetch after reset
    send_cmd(2'd0, 1'b0, 1, 8'h00, 8'h00, 1'b0);
    chk("s1_op_req", 32'(op_req), 32'd1);
    op_ack = 1'b1;
    tick();
    op_ack = 1'b0;
    chk("s1_valid_mac", 32'(valid_mac), 32'd1);
    finish_run(2);
    chk("s1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("s1_rsp_tiles", 32'(rsp_tiles), 32'd1);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
